// File: rtl/sample_sdiv_seq_11_if.sv
// Divider request/response bundle: clock enable, operands and start in; busy/done and results out.
interface sample_sdiv_seq_11_if #(
   parameter int unsigned WIDTH = 11
);
   logic             ce;
   logic             start;
   logic [WIDTH-1:0] din0;
   logic [WIDTH-1:0] din1;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             dbz;

   modport master (
      output ce, start, din0, din1,
      input  busy, done, quo, rem, dbz
   );

   modport slave (
      input  ce, start, din0, din1,
      output busy, done, quo, rem, dbz
   );
endinterface

// File: rtl/sample_sdiv_seq_11.sv
// Sequential signed restoring divider, one quotient bit per enabled cycle.
// Define SAMPLE_SDIV_REM_EN to build the remainder output; otherwise rem reads constant 0.
module sample_sdiv_seq_11 #(
   parameter int unsigned WIDTH = 11,
   parameter logic [31:0] ID    = 32'd1
) (
   input logic                 clk,
   input logic                 reset,
   sample_sdiv_seq_11_if.slave bus
);
   localparam int unsigned     CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load_c;
   logic             step_c;
   logic             fin_c;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   logic [WIDTH:0]   d_mag;
   logic             sign_q;
   logic             sign_r;
   logic             div_zero;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic [WIDTH-1:0] quo_q;

   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   b_ext;
   logic [WIDTH:0]   a_abs;
   logic [WIDTH:0]   b_abs;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH+1:0] diff;
   logic             borrow;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] quo_fin;
   logic [WIDTH-1:0] rem_fin;

   // State register; reset wins over ce.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else if (bus.ce) begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_CALC;
         S_CALC:  if (cnt == LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = bus.start ? S_CALC : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control strobes for the datapath.
   always_comb begin
      load_c = 1'b0;
      step_c = 1'b0;
      fin_c  = 1'b0;
      case (state)
         S_IDLE: load_c = bus.start;
         S_CALC: begin
            step_c = 1'b1;
            fin_c  = (cnt == LAST);
         end
         S_DONE: load_c = bus.start;
         default: ;
      endcase
   end

   // Magnitudes use one extra bit so -2^(WIDTH-1) is representable.
   always_comb begin
      a_ext   = {bus.din0[WIDTH-1], bus.din0};
      b_ext   = {bus.din1[WIDTH-1], bus.din1};
      a_abs   = a_ext[WIDTH] ? (~a_ext + (WIDTH+1)'(1)) : a_ext;
      b_abs   = b_ext[WIDTH] ? (~b_ext + (WIDTH+1)'(1)) : b_ext;
      r_sh    = {r_mag, q_mag[WIDTH-1]};
      diff    = {1'b0, r_sh} - {1'b0, d_mag};
      borrow  = diff[WIDTH+1];
      r_nxt   = borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      q_nxt   = {q_mag[WIDTH-2:0], ~borrow};
      quo_fin = div_zero ? '1 : (sign_q ? (~q_nxt + WIDTH'(1)) : q_nxt);
      rem_fin = sign_r ? (~r_nxt + WIDTH'(1)) : r_nxt;
   end

   // Operand capture, shift-subtract iteration and result registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt      <= '0;
         q_mag    <= '0;
         r_mag    <= '0;
         d_mag    <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         div_zero <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         quo_q    <= '0;
      end else if (bus.ce) begin
         done_q <= fin_c;
         if (load_c) begin
            q_mag    <= a_abs[WIDTH-1:0];
            r_mag    <= '0;
            d_mag    <= b_abs;
            sign_q   <= bus.din0[WIDTH-1] ^ bus.din1[WIDTH-1];
            sign_r   <= bus.din0[WIDTH-1];
            div_zero <= (bus.din1 == '0);
            cnt      <= '0;
            busy_q   <= 1'b1;
         end else if (step_c) begin
            q_mag <= q_nxt;
            r_mag <= r_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (fin_c) begin
               busy_q <= 1'b0;
               quo_q  <= quo_fin;
               dbz_q  <= div_zero;
            end
         end
      end
   end

`ifdef SAMPLE_SDIV_REM_EN
   logic [WIDTH-1:0] rem_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rem_q <= '0;
      end else if (bus.ce && fin_c) begin
         rem_q <= rem_fin;
      end
   end

   assign bus.rem = rem_q;
`else
   assign bus.rem = '0;
`endif

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.quo  = quo_q;
   assign bus.dbz  = dbz_q;

   // Bits that are provably zero or only consumed in some builds.
   logic unused_c;
   assign unused_c = ^{ID, a_abs[WIDTH], diff[WIDTH], rem_fin};
endmodule
